// File: rtl/option_fifo.sv
// Circular word FIFO between the board loader/solver re-queue path and the solver pop port.
// Latency: first-word-fall-through; a word pushed into an empty FIFO shows on rd_data the next cycle.
// Backpressure: wr_ready drops when full or during put_back; a put_back into a full FIFO is dropped unless a pop frees the slot.
module option_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  output logic          wr_ready,
  input  logic          put_back,
  input  logic [15:0]   pb_data,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic          rd_is_header,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [5:0]    lines_pending,
  output logic [15:0]   pass_cnt,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   head;
  logic [15:0]   push_dat;
  logic          push_req;
  logic          push_acc;
  logic          pop;
  logic          push_hdr;
  logic          pop_hdr;

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign wr_ready     = !full && !put_back;
  // Head is read from registered pointers only, so nothing on the push side reaches rd_data combinationally.
  assign head         = mem[rd_ptr];
  assign rd_data      = empty ? 16'h0000 : head;
  assign rd_is_header = head[15] && !empty;

  assign push_req = put_back || (wr_en && wr_ready);
  assign push_dat = put_back ? pb_data : wr_data;
  assign pop      = rd_en && !empty;
  // When full, a push only fits if the same cycle's pop frees the head slot.
  assign push_acc = push_req && (!full || pop);
  assign push_hdr = push_acc && push_dat[15];
  assign pop_hdr  = pop && head[15];

  always_ff @(posedge clk) begin
    if (rst_n && push_acc) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      lines_pending <= '0;
      pass_cnt      <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;

      case ({push_acc, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case ({push_hdr, pop_hdr})
        2'b10:   lines_pending <= lines_pending + 6'd1;
        2'b01:   lines_pending <= lines_pending - 6'd1;
        default: lines_pending <= lines_pending;
      endcase

      if (pop_hdr && (pass_cnt != 16'hFFFF)) pass_cnt <= pass_cnt + 16'd1;

      if (push_req && full && !pop) overflow  <= 1'b1;
      if (rd_en && empty)           underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_option_fifo.sv
// Directed bench for option_fifo: board load, re-queue pass, full/empty corners, pointer wrap, reset.
module tb_option_fifo;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          put_back;
  logic [15:0]   pb_data;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic          rd_is_header;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [5:0]    lines_pending;
  logic [15:0]   pass_cnt;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  option_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .put_back(put_back), .pb_data(pb_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_is_header(rd_is_header),
    .empty(empty), .full(full), .count(count),
    .lines_pending(lines_pending), .pass_cnt(pass_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; put_back = 1'b0; rd_en = 1'b0;
    wr_data = 16'h0000; pb_data = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_empty"},  32'(empty), 32'd1);
    chk({t, "_full"},   32'(full), 32'd0);
    chk({t, "_wrrdy"},  32'(wr_ready), 32'd1);
    chk({t, "_rddat"},  32'(rd_data), 32'h0);
    chk({t, "_hdr"},    32'(rd_is_header), 32'd0);
    chk({t, "_count"},  32'(count), 32'd0);
    chk({t, "_lines"},  32'(lines_pending), 32'd0);
    chk({t, "_pass"},   32'(pass_cnt), 32'd0);
    chk({t, "_ovf"},    32'(overflow), 32'd0);
    chk({t, "_unf"},    32'(underflow), 32'd0);
  endtask

  // 11x11 board: even slot = header for line k/2, odd slot = option pattern
  function automatic logic [15:0] brd_word(input int k);
    if (k % 2 == 0) return 16'h8000 | 16'(k / 2);
    return 16'h07FF ^ 16'(k / 2);
  endfunction

  function automatic logic [15:0] str_word(input int k);
    if (k % 5 == 0) return 16'h8000 | 16'(k % 22);
    return {5'b0, 11'(k * 7)};
  endfunction

  initial begin
    logic [15:0] q[$];
    int hdrs;
    bit ok;
    bit rdy_ok;
    bit cnt_ok;

    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_reset("rst0");

    // Board load
    for (int k = 0; k < 44; k++) begin
      wr_en = 1'b1; wr_data = brd_word(k);
      tick();
    end
    idle();
    #1;
    chk("load_count", 32'(count), 32'd44);
    chk("load_lines", 32'(lines_pending), 32'd22);
    chk("load_head",  32'(rd_data), 32'h8000);
    chk("load_ishdr", 32'(rd_is_header), 32'd1);

    // One solver pass: pop every word and re-queue it
    ok = 1; rdy_ok = 1; cnt_ok = 1;
    for (int k = 0; k < 44; k++) begin
      rd_en = 1'b1; put_back = 1'b1; pb_data = brd_word(k);
      wr_en = 1'b1; wr_data = 16'h7777;
      #1;
      if (rd_data !== brd_word(k)) ok = 0;
      if (wr_ready !== 1'b0) rdy_ok = 0;
      tick();
      if (count !== 9'd44) cnt_ok = 0;
    end
    idle();
    #1;
    chk("pass_order", 32'(ok), 32'd1);
    chk("pass_wrrdy", 32'(rdy_ok), 32'd1);
    chk("pass_count", 32'(cnt_ok), 32'd1);
    chk("pass_cnt",   32'(pass_cnt), 32'd22);
    chk("pass_lines", 32'(lines_pending), 32'd22);
    chk("pass_head",  32'(rd_data), 32'h8000);
    chk("pass_wrrdy_idle", 32'(wr_ready), 32'd1);

    // Fill to DEPTH, overflow, then put_back alongside a pop
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_data = 16'(k + 1);
      tick();
    end
    idle();
    #1;
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_wrrdy", 32'(wr_ready), 32'd0);
    put_back = 1'b1; pb_data = 16'h0555;
    tick();
    idle();
    #1;
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_head",  32'(rd_data), 32'h0001);
    put_back = 1'b1; pb_data = 16'h8015; rd_en = 1'b1;
    tick();
    idle();
    #1;
    chk("pbfull_count", 32'(count), 32'(DEPTH));
    chk("pbfull_head",  32'(rd_data), 32'h0002);
    chk("pbfull_lines", 32'(lines_pending), 32'd1);
    ok = 1;
    for (int k = 1; k < DEPTH; k++) begin
      rd_en = 1'b1;
      if (rd_data !== 16'(k + 1)) ok = 0;
      tick();
    end
    idle();
    #1;
    chk("drain_order", 32'(ok), 32'd1);
    chk("drain_last",  32'(rd_data), 32'h8015);
    rd_en = 1'b1;
    tick();
    idle();
    #1;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_pass",  32'(pass_cnt), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Empty corners
    do_reset();
    rd_en = 1'b1;
    tick();
    idle();
    #1;
    chk("unf_flag",  32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_rddat", 32'(rd_data), 32'h0);
    wr_en = 1'b1; wr_data = 16'h0123; rd_en = 1'b1;
    tick();
    idle();
    #1;
    chk("sim_rddat", 32'(rd_data), 32'h0123);
    chk("sim_count", 32'(count), 32'd1);
    chk("sim_unf",   32'(underflow), 32'd1);

    // 3*DEPTH words through pointer wrap
    do_reset();
    q = {}; hdrs = 0; ok = 1;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      wr_en = 1'b1; wr_data = str_word(c);
      rd_en = (q.size() > 0 && c % 4 != 0) ? 1'b1 : 1'b0;
      if (rd_en) begin
        if (rd_data !== q[0]) ok = 0;
        if (q[0][15]) hdrs++;
        void'(q.pop_front());
      end
      q.push_back(str_word(c));
      tick();
    end
    idle();
    #1;
    chk("wrap_count_mid", 32'(count), 32'(q.size()));
    for (int n = q.size(); n > 0; n--) begin
      rd_en = 1'b1;
      if (rd_data !== q[0]) ok = 0;
      if (q[0][15]) hdrs++;
      void'(q.pop_front());
      tick();
    end
    idle();
    #1;
    chk("wrap_data",  32'(ok), 32'd1);
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_pass",  32'(pass_cnt), 32'(hdrs));
    chk("wrap_lines", 32'(lines_pending), 32'd0);
    chk("wrap_unf",   32'(underflow), 32'd0);

    // Mid-stream reset with count=10 and overflow set
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_data = 16'h8000 | 16'(k % 4 == 0 ? 1 : 0);
      wr_data[15] = 1'b0;
      tick();
    end
    idle();
    put_back = 1'b1; pb_data = 16'h0AAA;
    tick();
    idle();
    for (int k = 0; k < DEPTH - 10; k++) begin
      rd_en = 1'b1;
      tick();
    end
    idle();
    #1;
    chk("pre_rst_count", 32'(count), 32'd10);
    chk("pre_rst_ovf",   32'(overflow), 32'd1);
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 16'h8111;
    put_back = 1'b1; pb_data = 16'h8222; rd_en = 1'b1;
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    chk_reset("rst1");
    wr_en = 1'b1; wr_data = 16'h8005;
    tick();
    idle();
    #1;
    chk("post_rst_rddat", 32'(rd_data), 32'h8005);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_hdr",   32'(rd_is_header), 32'd1);
    chk("post_rst_lines", 32'(lines_pending), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/option_fifo.md
OPTION_FIFO -- requirements
Module: option_fifo

Parameters
REQ-001 DEPTH, default 256, number of 16-bit entries, power of two, at least 4.
REQ-002 AW, default $clog2(DEPTH), pointer width.

Interface
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous reset, active-low.
REQ-005 wr_en  in  1  host load request; accepted only when wr_ready=1.
REQ-006 wr_data  in  16  host word; bit15=1 marks a header, bits4:0=line index (0..21); bit15=0 marks an option, bits10:0=cell pattern.
REQ-007 wr_ready  out  1  equals !full && !put_back.
REQ-008 put_back  in  1  solver re-queues a surviving option or header; has priority over wr_en.
REQ-009 pb_data  in  16  word re-queued by the solver; same format as wr_data.
REQ-010 rd_en  in  1  solver pop (read_from_fifo); ignored when empty.
REQ-011 rd_data  out  16  head word, first-word-fall-through; 16'h0000 when empty.
REQ-012 rd_is_header  out  1  rd_data[15] && !empty.
REQ-013 empty, full  out  1 each  count==0 and count==DEPTH respectively.
REQ-014 count  out  AW+1  number of stored words.
REQ-015 lines_pending  out  6  number of header words currently stored.
REQ-016 pass_cnt  out  16  headers popped since reset; saturates at 16'hFFFF.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Storage is a circular buffer with wr_ptr and rd_ptr of AW bits, both wrapping from DEPTH-1 to 0.
REQ-019 Push source per cycle: pb_data if put_back=1, otherwise wr_data if wr_en && wr_ready; at most one push per cycle.
REQ-020 A push when full and rd_en=0 is dropped, sets overflow, and leaves pointers and count unchanged.
REQ-021 A put_back when full with rd_en=1 is accepted: pop and push occur in the same cycle and count is unchanged.
REQ-022 rd_en=1 when empty sets underflow and changes no other state.
REQ-023 A simultaneous push and pop on an empty FIFO performs only the push; the pushed word appears on rd_data the next cycle and underflow is set.
REQ-024 Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 lines_pending increments on a header push and decrements on a header pop; it is unchanged when both occur in the same cycle.
REQ-026 pass_cnt increments on every header pop (rd_en && !empty && rd_data[15]).
REQ-027 rd_data reflects the head in the cycle after any push to an empty FIFO or any pop; there is no combinational path from wr_en or put_back to rd_data.
REQ-028 wr_ready falls combinationally when put_back=1, so the host stalls for one cycle and loses no data.
REQ-029 overflow and underflow clear only on reset.
REQ-030 Words leave in strict push order; a re-queued word lands behind all words already stored.

Reset
REQ-031 When rst_n=0 at a clock edge, the following SHALL be zero: wr_ptr, rd_ptr, count, lines_pending, pass_cnt, overflow, underflow. After that edge, empty=1, full=0, wr_ready=1 and rd_data=0.
REQ-032 Reset mid-stream discards all stored words; the RAM contents need not be cleared.
REQ-033 Any wr_en, put_back or rd_en in the reset cycle has no effect.

Verification
REQ-034 Load 11x11 board: push header 16'h8000, option 16'h07FF, and so on for all 22 lines (44 words) -> count=44, lines_pending=22, rd_data=16'h8000, rd_is_header=1.
REQ-035 Pop all 44 words while put_back re-queues each one -> order preserved, count stays 44 after the first cycle, pass_cnt=22, wr_ready=0 on every put_back cycle.
REQ-036 Fill DEPTH words, then push with rd_en=0 -> overflow=1, count=DEPTH; then put_back with rd_en=1 -> accepted, count=DEPTH.
REQ-037 rd_en on empty -> underflow=1, count=0; same-cycle wr_en on empty with 16'h0123 -> next cycle rd_data=16'h0123, count=1.
REQ-038 Push/pop 3*DEPTH words through pointer wrap -> data intact, empty at end, pass_cnt matches the number of headers popped.
REQ-039 Assert rst_n=0 with count=10 and overflow=1 -> next cycle all outputs equal their reset values and a following push of 16'h8005 yields rd_data=16'h8005.
